// File: rtl/intellight_db_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : intellight_db_pkg
//  Description : Shared definitions for the intellight_database_regfile
//                AXI4-Lite register file: response codes, the write and read
//                channel state encodings, an index-width helper and the
//                byte-strobe word merge.
//  Revision    : 1.0 - initial release
// ============================================================================
package intellight_db_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

    // Width of a register index; a single-register file still gets one bit
    // so that no port or signal collapses to zero width.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Byte-strobe merge on a 64-bit container. Callers zero-extend narrower
    // words and strobes; unset strobe bits keep the old byte.
    function automatic logic [63:0] strb_merge(input logic [63:0] old_word,
                                               input logic [63:0] new_word,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        res = old_word;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/intellight_db_wr_chan.sv
`default_nettype none
// ============================================================================
//  Module      : intellight_db_wr_chan
//  Description : AXI4-Lite write channel. Accepts AW and W in any order
//                (or together), latches whichever arrives first, decodes the
//                register index, produces BRESP and a single-cycle commit
//                strobe towards the register array.
//  Ports       : clk_i/rst_i          clock, synchronous active-high reset
//                awaddr_i/awvalid_i/awready_o   write address channel
//                wdata_i/wstrb_i/wvalid_i/wready_o  write data channel
//                bresp_o/bvalid_o/bready_i      write response channel
//                commit_o             one-cycle write strobe (writable reg)
//                commit_idx_o/_data_o/_strb_o   target index, data, strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module intellight_db_wr_chan
    import intellight_db_pkg::*;
#(
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          NUM_REGS = 16,
    parameter int unsigned          ADDR_W   = 8,
    parameter logic [NUM_REGS-1:0]  RO_MASK  = '0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [ADDR_W-1:0]                 awaddr_i,
    input  logic                              awvalid_i,
    output logic                              awready_o,
    input  logic [DATA_W-1:0]                 wdata_i,
    input  logic [DATA_W/8-1:0]               wstrb_i,
    input  logic                              wvalid_i,
    output logic                              wready_o,
    output logic [1:0]                        bresp_o,
    output logic                              bvalid_o,
    input  logic                              bready_i,
    output logic                              commit_o,
    output logic [idx_width(NUM_REGS)-1:0]    commit_idx_o,
    output logic [DATA_W-1:0]                 commit_data_o,
    output logic [DATA_W/8-1:0]               commit_strb_o
);

    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned OFS_W     = $clog2(STRB_W);
    localparam int unsigned AIDX_W    = ADDR_W - OFS_W;
    localparam int unsigned REG_IDX_W = idx_width(NUM_REGS);

    wr_state_e              state_q, state_d;
    logic [AIDX_W-1:0]      aidx_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [STRB_W-1:0]      wstrb_q;
    logic [1:0]             bresp_q;

    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_fire;
    logic [AIDX_W-1:0]      w_cmt_aidx;
    logic [REG_IDX_W-1:0]   w_reg_idx;
    logic                   w_in_range;
    logic                   w_unused_addr;

    // Ready depends on reset as well as state so that nothing is accepted
    // while reset is held, even though the state already reads IDLE.
    assign awready_o = !rst_i && ((state_q == W_IDLE) || (state_q == W_HAVE_DATA));
    assign wready_o  = !rst_i && ((state_q == W_IDLE) || (state_q == W_HAVE_ADDR));
    assign w_aw_hs   = awvalid_i && awready_o;
    assign w_w_hs    = wvalid_i  && wready_o;

    // Both halves are available when each is either latched or handshaking now.
    assign w_fire = (w_aw_hs || (state_q == W_HAVE_ADDR)) &&
                    (w_w_hs  || (state_q == W_HAVE_DATA));

    assign w_cmt_aidx    = (state_q == W_HAVE_ADDR) ? aidx_q  : awaddr_i[ADDR_W-1:OFS_W];
    assign commit_data_o = (state_q == W_HAVE_DATA) ? wdata_q : wdata_i;
    assign commit_strb_o = (state_q == W_HAVE_DATA) ? wstrb_q : wstrb_i;

    assign w_in_range   = (32'(w_cmt_aidx) < NUM_REGS);
    assign w_reg_idx    = w_cmt_aidx[REG_IDX_W-1:0];
    assign commit_idx_o = w_reg_idx;
    // Hardware-owned registers still get an OKAY response; only the store is suppressed.
    assign commit_o     = w_fire && w_in_range && !RO_MASK[w_reg_idx];

    assign bresp_o  = bresp_q;
    assign bvalid_o = (state_q == W_RESP);

    // Byte-offset bits do not participate in decode.
    assign w_unused_addr = &{1'b0, awaddr_i[OFS_W-1:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            W_IDLE: begin
                if (w_fire) begin
                    state_d = W_RESP;
                end else if (w_aw_hs) begin
                    state_d = W_HAVE_ADDR;
                end else if (w_w_hs) begin
                    state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR,
            W_HAVE_DATA: begin
                if (w_fire) begin
                    state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bready_i) begin
                    state_d = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= W_IDLE;
            aidx_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bresp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            if (w_aw_hs) begin
                aidx_q <= awaddr_i[ADDR_W-1:OFS_W];
            end
            if (w_w_hs) begin
                wdata_q <= wdata_i;
                wstrb_q <= wstrb_i;
            end
            if (w_fire) begin
                bresp_q <= w_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/intellight_database_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : intellight_database_regfile
//  Description : Parametrised AXI4-Lite slave register file with byte-strobe
//                writes, hardware-owned (read-only) slots, a hardware update
//                port and SLVERR decode for out-of-range addresses.
//  Ports       : S_AXI_ACLK / S_AXI_ARESET   clock, sync active-high reset
//                S_AXI_AW*, S_AXI_W*, S_AXI_B*   AXI4-Lite write channels
//                S_AXI_AR*, S_AXI_R*             AXI4-Lite read channels
//                hw_wr_en/idx/data   full-word hardware update
//                hw_wr_drop          pulse: hardware update lost to a bus write
//                reg_out             flattened register contents
//                wr_irq / irq_ack    sticky write interrupt (optional)
//  Options     : define INTELLIGHT_DB_WR_IRQ_EN to add wr_irq / irq_ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module intellight_database_regfile
    import intellight_db_pkg::*;
#(
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          NUM_REGS = 16,
    parameter int unsigned          ADDR_W   = 8,
    parameter logic [NUM_REGS-1:0]  RO_MASK  = '0
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [ADDR_W-1:0]                 S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [DATA_W-1:0]                 S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]               S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [ADDR_W-1:0]                 S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [DATA_W-1:0]                 S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              hw_wr_en,
    input  logic [idx_width(NUM_REGS)-1:0]    hw_wr_idx,
    input  logic [DATA_W-1:0]                 hw_wr_data,
    output logic                              hw_wr_drop,
`ifdef INTELLIGHT_DB_WR_IRQ_EN
    output logic                              wr_irq,
    input  logic                              irq_ack,
`endif
    output logic [NUM_REGS*DATA_W-1:0]        reg_out
);

    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned OFS_W     = $clog2(STRB_W);
    localparam int unsigned AIDX_W    = ADDR_W - OFS_W;
    localparam int unsigned REG_IDX_W = idx_width(NUM_REGS);

    logic [DATA_W-1:0]      regs_q [NUM_REGS];
    logic                   drop_q;

    logic                   w_commit;
    logic [REG_IDX_W-1:0]   w_cmt_idx;
    logic [DATA_W-1:0]      w_cmt_data;
    logic [STRB_W-1:0]      w_cmt_strb;
    logic [DATA_W-1:0]      w_merged;

    rd_state_e              rd_state_q, rd_state_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [1:0]             rresp_q, rresp_d;
    logic                   w_ar_hs;
    logic [AIDX_W-1:0]      w_ar_aidx;
    logic [REG_IDX_W-1:0]   w_ar_ridx;
    logic                   w_ar_in_range;
    logic                   w_unused_araddr;

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    intellight_db_wr_chan #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .RO_MASK  (RO_MASK)
    ) u_wr_chan (
        .clk_i         (S_AXI_ACLK),
        .rst_i         (S_AXI_ARESET),
        .awaddr_i      (S_AXI_AWADDR),
        .awvalid_i     (S_AXI_AWVALID),
        .awready_o     (S_AXI_AWREADY),
        .wdata_i       (S_AXI_WDATA),
        .wstrb_i       (S_AXI_WSTRB),
        .wvalid_i      (S_AXI_WVALID),
        .wready_o      (S_AXI_WREADY),
        .bresp_o       (S_AXI_BRESP),
        .bvalid_o      (S_AXI_BVALID),
        .bready_i      (S_AXI_BREADY),
        .commit_o      (w_commit),
        .commit_idx_o  (w_cmt_idx),
        .commit_data_o (w_cmt_data),
        .commit_strb_o (w_cmt_strb)
    );

    assign w_merged = DATA_W'(strb_merge(64'(regs_q[w_cmt_idx]),
                                         64'(w_cmt_data),
                                         8'(w_cmt_strb)));

    // ------------------------------------------------------------------
    // Register array. A bus commit takes priority over a hardware update
    // to the same slot; bus commits never target hardware-owned slots, so
    // those always take the hardware value.
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            drop_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (w_commit && (w_cmt_idx == REG_IDX_W'(i))) begin
                    regs_q[i] <= w_merged;
                end else if (hw_wr_en && (hw_wr_idx == REG_IDX_W'(i))) begin
                    regs_q[i] <= hw_wr_data;
                end
            end
            drop_q <= hw_wr_en && w_commit && (hw_wr_idx == w_cmt_idx);
        end
    end

    assign hw_wr_drop = drop_q;

    for (genvar gi = 0; gi < int'(NUM_REGS); gi++) begin : g_out
        assign reg_out[gi*DATA_W +: DATA_W] = regs_q[gi];
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    assign S_AXI_ARREADY   = !S_AXI_ARESET && (rd_state_q == R_IDLE);
    assign w_ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
    assign w_ar_aidx       = S_AXI_ARADDR[ADDR_W-1:OFS_W];
    assign w_ar_ridx       = w_ar_aidx[REG_IDX_W-1:0];
    assign w_ar_in_range   = (32'(w_ar_aidx) < NUM_REGS);
    assign w_unused_araddr = &{1'b0, S_AXI_ARADDR[OFS_W-1:0]};

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (w_ar_hs) begin
                    rd_state_d = R_RESP;
                    if (w_ar_in_range) begin
                        rdata_d = regs_q[w_ar_ridx];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            R_RESP: begin
                if (S_AXI_RREADY) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign S_AXI_RVALID = (rd_state_q == R_RESP);
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;

`ifdef INTELLIGHT_DB_WR_IRQ_EN
    // ------------------------------------------------------------------
    // Sticky write interrupt: set by any stored bus write with at least one
    // strobe; a same-cycle acknowledge loses to a new set.
    // ------------------------------------------------------------------
    logic wr_irq_q;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_irq_q <= 1'b0;
        end else if (w_commit && (|w_cmt_strb)) begin
            wr_irq_q <= 1'b1;
        end else if (irq_ack) begin
            wr_irq_q <= 1'b0;
        end
    end

    assign wr_irq = wr_irq_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_intellight_database_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intellight_database_regfile
//  Description : Self-checking bench for intellight_database_regfile with
//                NUM_REGS=8, DATA_W=32, ADDR_W=8, RO_MASK=8'h80. Directed
//                scenarios followed by randomized bus and hardware traffic,
//                checked against an array-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_intellight_database_regfile;

    localparam int         NR = 8;
    localparam logic [7:0] RO = 8'h80;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [7:0]   araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic         hw_wr_en;
    logic [2:0]   hw_wr_idx;
    logic [31:0]  hw_wr_data;
    logic         hw_wr_drop;
    logic [255:0] reg_out;

    int           n_cmp = 0;
    int           n_bad = 0;
    bit           g_hw_on = 1'b0;
    logic [31:0]  m_regs [NR];

    always #5 clk = ~clk;

    intellight_database_regfile #(
        .DATA_W   (32),
        .NUM_REGS (8),
        .ADDR_W   (8),
        .RO_MASK  (8'h80)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .hw_wr_en      (hw_wr_en),
        .hw_wr_idx     (hw_wr_idx),
        .hw_wr_data    (hw_wr_data),
        .hw_wr_drop    (hw_wr_drop),
        .reg_out       (reg_out)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < NR; i++) f[i*32 +: 32] = m_regs[i];
        return f;
    endfunction

    // One clock: predicts the edge from the values driven now, advances,
    // updates the model and checks the collision pulse.
    task automatic clk_cycle(input bit commit, input logic [7:0] c_addr,
                             input logic [31:0] c_data, input logic [3:0] c_strb);
        bit          pre_rst;
        bit          hw;
        int          hidx;
        logic [31:0] hdata;
        logic [5:0]  bidx;
        bit          wr_ok;
        bit          exp_drop;
        pre_rst  = rst;
        hw       = hw_wr_en;
        hidx     = int'(hw_wr_idx);
        hdata    = hw_wr_data;
        bidx     = c_addr[7:2];
        wr_ok    = commit && !pre_rst && (bidx < 6'(NR)) && !RO[bidx[2:0]];
        exp_drop = hw && !pre_rst && wr_ok && (hidx == int'(bidx));
        @(posedge clk);
        #1;
        if (pre_rst) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
        end else begin
            if (wr_ok) begin
                for (int b = 0; b < 4; b++)
                    if (c_strb[b]) m_regs[bidx[2:0]][8*b +: 8] = c_data[8*b +: 8];
            end
            if (hw && !exp_drop) m_regs[hidx] = hdata;
        end
        chk("hw_drop", hw_wr_drop, exp_drop);
        if (g_hw_on && ($urandom_range(0, 3) == 0)) begin
            hw_wr_en   = 1'b1;
            hw_wr_idx  = 3'($urandom_range(0, 7));
            hw_wr_data = $urandom;
        end else begin
            hw_wr_en   = 1'b0;
        end
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_dly, input bit reset_in_resp);
        bit aw_done;
        bit w_done;
        bit aw_fire;
        bit w_fire;
        bit cm;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done  && (cyc >= w_dly);
            #1;
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            cm      = (aw_done || aw_fire) && (w_done || w_fire);
            clk_cycle(cm, addr, data, strb);
            aw_done = aw_done | aw_fire;
            w_done  = w_done | w_fire;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("wr_accept", {aw_done, w_done}, 2'b11);
        if (!(aw_done && w_done)) return;
        chk("bvalid_rise", bvalid, 1'b1);
        chk("bresp", bresp, (addr[7:2] >= 6'(NR)) ? 2'b10 : 2'b00);
        chk("regs_after_wr", reg_out, model_flat());
        if (reset_in_resp) begin
            rst = 1'b1;
            hw_wr_en = 1'b0;
            clk_cycle(1'b0, 8'h0, 32'h0, 4'h0);
            chk("rst_bvalid", bvalid, 1'b0);
            chk("rst_regs", reg_out, 256'h0);
            chk("rst_readies", {awready, wready, arready}, 3'b000);
            chk("rst_resp", {rvalid, bresp, rresp, rdata}, 37'h0);
            rst = 1'b0;
            return;
        end
        for (int i = 0; i < b_dly; i++) begin
            clk_cycle(1'b0, 8'h0, 32'h0, 4'h0);
            chk("bvalid_hold", bvalid, 1'b1);
            chk("rdy_in_resp", {awready, wready}, 2'b00);
        end
        bready = 1'b1;
        clk_cycle(1'b0, 8'h0, 32'h0, 4'h0);
        bready = 1'b0;
        chk("bvalid_fall", bvalid, 1'b0);
    endtask

    task automatic bus_read(input logic [7:0] addr, input int ar_dly, input int r_dly,
                            output logic [31:0] got);
        bit          fire;
        int          cyc;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        fire = 0; cyc = 0; exp_d = '0; exp_r = 2'b00; got = '0;
        araddr = addr;
        while (!fire && cyc < 40) begin
            arvalid = (cyc >= ar_dly);
            #1;
            fire = arvalid && arready;
            if (fire) begin
                exp_d = (addr[7:2] < 6'(NR)) ? m_regs[addr[4:2]] : 32'h0;
                exp_r = (addr[7:2] < 6'(NR)) ? 2'b00 : 2'b10;
            end
            clk_cycle(1'b0, 8'h0, 32'h0, 4'h0);
            cyc++;
        end
        arvalid = 1'b0;
        chk("rd_accept", fire, 1'b1);
        if (!fire) return;
        chk("rvalid_rise", rvalid, 1'b1);
        chk("rdata", rdata, exp_d);
        chk("rresp", rresp, exp_r);
        got = rdata;
        for (int i = 0; i < r_dly; i++) begin
            clk_cycle(1'b0, 8'h0, 32'h0, 4'h0);
            chk("rvalid_hold", rvalid, 1'b1);
            chk("rdata_hold", rdata, exp_d);
        end
        rready = 1'b1;
        clk_cycle(1'b0, 8'h0, 32'h0, 4'h0);
        rready = 1'b0;
        chk("rvalid_fall", rvalid, 1'b0);
    endtask

    initial begin
        logic [31:0]  got;
        logic [255:0] snap;
        logic [7:0]   a;
        rst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        hw_wr_en = 1'b0; hw_wr_idx = '0; hw_wr_data = '0;
        for (int i = 0; i < NR; i++) m_regs[i] = '0;

        // Reset state
        clk_cycle(1'b0, 8'h0, 32'h0, 4'h0);
        clk_cycle(1'b0, 8'h0, 32'h0, 4'h0);
        chk("reset_regs", reg_out, 256'h0);
        chk("reset_outs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata},
            41'h0);
        rst = 1'b0;
        clk_cycle(1'b0, 8'h0, 32'h0, 4'h0);
        chk("idle_readies", {awready, wready, arready}, 3'b111);

        // AW and W together, then read back
        bus_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0);
        bus_read(8'h04, 0, 0, got);
        chk("t1_readback", got, 32'hDEADBEEF);

        // W three cycles ahead of AW, partial strobes over all-ones
        hw_wr_en = 1'b1; hw_wr_idx = 3'd2; hw_wr_data = 32'hFFFFFFFF;
        clk_cycle(1'b0, 8'h0, 32'h0, 4'h0);
        chk("t2_preload", reg_out[95:64], 32'hFFFFFFFF);
        bus_write(8'h08, 32'h11223344, 4'b0101, 3, 0, 1, 1'b0);
        chk("t2_merge", reg_out[95:64], 32'hFF22FF44);

        // Out of range write and read
        snap = reg_out;
        bus_write(8'h20, 32'hAAAA5555, 4'hF, 0, 1, 0, 1'b0);
        chk("t3_no_change", reg_out, snap);
        bus_read(8'h20, 1, 1, got);
        chk("t3_oor_data", got, 32'h0);

        // Hardware-owned register: bus ignored, hardware port works
        bus_write(8'h1C, 32'h5, 4'hF, 0, 0, 0, 1'b0);
        chk("t4_ro_unchanged", reg_out[255:224], 32'h0);
        hw_wr_en = 1'b1; hw_wr_idx = 3'd7; hw_wr_data = 32'hA5;
        clk_cycle(1'b0, 8'h0, 32'h0, 4'h0);
        chk("t4_hw_ro", reg_out[255:224], 32'hA5);

        // Collision on an RW register, response held off for 5 cycles
        hw_wr_en = 1'b1; hw_wr_idx = 3'd2; hw_wr_data = 32'h2;
        bus_write(8'h08, 32'h1, 4'hF, 0, 0, 5, 1'b0);
        chk("t5_bus_wins", reg_out[95:64], 32'h1);

        // Zero strobes: legal no-op
        snap = reg_out;
        bus_write(8'h0C, 32'h12345678, 4'h0, 1, 2, 0, 1'b0);
        chk("t6_nostrb", reg_out, snap);

        // Reset while the response is pending, then a fresh transaction
        bus_write(8'h10, 32'h12345678, 4'hF, 0, 0, 0, 1'b1);
        bus_write(8'h14, 32'hCAFEF00D, 4'hF, 1, 0, 0, 1'b0);
        bus_read(8'h14, 0, 0, got);
        chk("t7_after_reset", got, 32'hCAFEF00D);

        // Randomized traffic with background hardware updates
        g_hw_on = 1'b1;
        repeat (60) begin
            a = 8'($urandom_range(0, 39));
            if ($urandom_range(0, 1) == 1)
                bus_write(a, $urandom, 4'($urandom), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
            else
                bus_read(a, $urandom_range(0, 2), $urandom_range(0, 2), got);
            chk("rand_regs", reg_out, model_flat());
        end
        g_hw_on = 1'b0;
        clk_cycle(1'b0, 8'h0, 32'h0, 4'h0);
        chk("final_regs", reg_out, model_flat());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
